peripheral_bfm_slave_axi4: RTL and testbench
============================================

# peripheral_bfm_slave_axi4

Synthesizable AXI4 slave bus functional model: the responder end of the MPSoC peripheral BFM master. Accepts write and read bursts on independent channels, backs them with an internal word-addressed byte-enabled memory, and returns OKAY/SLVERR responses. Used in DMA and peripheral benches as the target for master-generated traffic.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; fixed 32 (4 byte lanes)
- ID_WIDTH, 4, transaction ID width
- MEM_DEPTH, 256, memory words; power of two
- BASE_ADDR, 32'h0, byte address of word 0

- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awid / awadr / awlen / awsize / awburst  in  ID_WIDTH / ADDR_WIDTH / 4 / 3 / 2  write address channel
- awvalid  in  1 ; awready  out  1  AW handshake
- wid / wrdata / wstrb / wlast  in  ID_WIDTH / 32 / 4 / 1  write data channel (wid ignored)
- wvalid  in  1 ; wready  out  1  W handshake
- bid / bresp  out  ID_WIDTH / 2  write response; bvalid  out  1 ; bready  in  1
- arid / araddr / arlen / arsize / arburst  in  ID_WIDTH / ADDR_WIDTH / 4 / 3 / 2  read address channel
- arvalid  in  1 ; arready  out  1  AR handshake
- rid / rdata / rresp / rlast  out  ID_WIDTH / 32 / 2 / 1  read data; rvalid  out  1 ; rready  in  1

## Operation
- Write FSM: W_IDLE -> (awvalid&awready) -> W_DATA -> (last counted beat accepted) -> W_RESP -> (bvalid&bready) -> W_IDLE.
- Read FSM: R_IDLE -> (arvalid&arready) -> R_DATA -> (beat arlen accepted) -> R_IDLE. FSMs fully independent; one outstanding burst per direction.
- On AW/AR handshake latch id, address, len, size, burst; beat counter cleared.
- Burst length = len+1 beats (1..16). FIXED (00): address constant. INCR (01): address +4 per beat. WRAP (10) and 11: whole burst SLVERR.
- awsize/arsize != 3'b010: whole burst SLVERR.
- Word index = (addr - BASE_ADDR) >> 2; beat in range iff addr >= BASE_ADDR and index < MEM_DEPTH; otherwise beat SLVERR.
- Write beat: byte lane i written iff wstrb[i] and beat not in error. Errored beats are consumed, memory untouched.
- wlast mismatch (asserted before final beat or absent on final beat): bresp SLVERR; burst still ends after exactly len+1 beats.
- bresp = 2'b10 if any beat errored, else 2'b00; bid = latched awid.
- Read beat: rdata = memory word, rresp 2'b00; errored beat: rdata 0, rresp 2'b10. rid = latched arid; rlast high on beat len only.
- Same-word write and read in one cycle: read returns pre-write value.
- Memory initialised to zero at time zero; not cleared by areset.

## Timing
- areset high: both FSMs idle, counters 0; awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rdata, rresp = 0. Reset mid-burst abandons burst; memory retains contents.
- awready = W_IDLE & !areset; arready = R_IDLE & !areset (combinational from state).
- AW handshake cycle N: wready high from N+1 through final beat; one beat per cycle when wvalid held.
- Final W beat cycle M: bvalid high M+1, held with bid/bresp stable until bready; awready high the cycle after B handshake.
- AR handshake cycle N: rvalid with beat 0 from N+1. Outputs stable while rvalid & !rready; next beat presented the cycle after each handshake (back-to-back, rvalid stays high).
- Final R handshake cycle M: rvalid low and arready high at M+1.
- Address/counter arithmetic in ADDR_WIDTH bits, wraps modulo 2^ADDR_WIDTH (wrapped address then out of range -> SLVERR).

## Test plan
- INCR write awadr=0x10, awlen=3, data 0xA0..0xA3, wstrb=4'hF -> wready 4 cycles, bvalid next cycle, bresp=00, bid=awid; INCR read same -> rdata 0xA0..0xA3, rlast on beat 3, rresp=00.
- Write 0xFFFFFFFF then wstrb=4'b0101 data 0x11223344 to 0x0 -> read returns 0xFF22FF44.
- FIXED write awlen=2 to 0x20 data 1,2,3 -> read 0x20 returns 3; read FIXED arlen=1 -> 3,3.
- awadr=BASE_ADDR+4*MEM_DEPTH-4, INCR awlen=1 -> beat 0 written, bresp=10; read same -> rresp 00 then 10, rdata 0 on beat 1.
- awsize=3'b001, or wlast on beat 0 of awlen=1 -> bresp=10, memory unchanged in the first case; rready toggled randomly during 16-beat read -> rdata/rlast stable while stalled, no beat lost.
- areset pulsed mid-write (after beat 1 of 4) -> all outputs zero, awready high after release, new burst completes with bresp=00, earlier-written beats retained.

Source files
------------

// File: rtl/peripheral_bfm_slave_axi4.sv
// AXI4 slave bus functional model: independent write and read burst engines
// in front of a word-addressed, byte-enabled memory. Bad size/burst type or
// out-of-range beats are answered with SLVERR; one burst outstanding per side.
module peripheral_bfm_slave_axi4 #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    areset,
    // write address channel
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awadr,
    input  logic [3:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    // write data channel
    input  logic [ID_WIDTH-1:0]     wid,
    input  logic [DATA_WIDTH-1:0]   wrdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    // write response channel
    output logic [ID_WIDTH-1:0]     bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    // read address channel
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [3:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    // read data channel
    output logic [ID_WIDTH-1:0]     rid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // Beat lies inside the memory window; the subtraction wraps, so addresses
    // below BASE_ADDR are rejected explicitly.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && ((off >> 2) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    // FIXED holds the address; everything else that survives the burst check is INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + ADDR_WIDTH'(4);
    endfunction

    // Only 32-bit beats with FIXED or INCR bursts are served.
    function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // write side state
    w_state_t              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [3:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]            wburst_q, wburst_d;
    logic                  wbad_q, wbad_d, werr_q, werr_d;
    logic [ID_WIDTH-1:0]   bid_q, bid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_hs, w_hs, b_hs, w_final, w_beat_err, w_any_err, mem_we;
    logic [IDX_W-1:0]      mem_widx;

    // read side state
    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [3:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]            rburst_q, rburst_d;
    logic                  rbad_q, rbad_d, rlast_q, rlast_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_hs, r_hs, r_final, fetch_en, fetch_bad, fetch_err;
    logic [ADDR_WIDTH-1:0] fetch_addr;

    logic unused_wid;
    assign unused_wid = ^wid;

    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign b_hs    = bvalid & bready;
    assign w_final = (wcnt_q == wlen_q);
    assign ar_hs   = arvalid & arready;
    assign r_hs    = rvalid & rready;
    assign r_final = (rcnt_q == rlen_q);

    // Write FSM state and burst registers; memory is deliberately outside reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wburst_q  <= '0;
            wbad_q    <= 1'b0;
            werr_q    <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wcnt_q    <= wcnt_d;
            wburst_q  <= wburst_d;
            wbad_q    <= wbad_d;
            werr_q    <= werr_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write FSM next state: the burst ends on the counted beat, whatever wlast says.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write datapath: latch the burst, then per beat check, store and accumulate errors.
    always_comb begin
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wcnt_d     = wcnt_q;
        wburst_d   = wburst_q;
        wbad_d     = wbad_q;
        werr_d     = werr_q;
        bid_d      = bid_q;
        bresp_d    = bresp_q;
        w_beat_err = wbad_q | ~in_range(waddr_q);
        w_any_err  = w_beat_err | (wlast != w_final);
        mem_we     = w_hs & ~w_beat_err;
        mem_widx   = word_idx(waddr_q);
        if (aw_hs) begin
            waddr_d  = awadr;
            wlen_d   = awlen;
            wcnt_d   = '0;
            wburst_d = awburst;
            wbad_d   = burst_bad(awsize, awburst);
            werr_d   = 1'b0;
            bid_d    = awid;
        end else if (w_hs) begin
            if (w_final) begin
                bresp_d = (werr_q | w_any_err) ? 2'b10 : 2'b00;
            end else begin
                werr_d  = werr_q | w_any_err;
                wcnt_d  = wcnt_q + 4'd1;
                waddr_d = next_addr(waddr_q, wburst_q);
            end
        end
    end

    // Write channel handshake outputs decoded from state.
    always_comb begin
        awready = (w_state_q == W_IDLE) & ~areset;
        wready  = (w_state_q == W_DATA);
        bvalid  = (w_state_q == W_RESP);
        bid     = bid_q;
        bresp   = bresp_q;
    end

    // Byte-lane memory write; reads sample the old word in the same cycle.
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wstrb[i]) mem[mem_widx][8*i +: 8] <= wrdata[8*i +: 8];
            end
        end
    end

    // Read FSM state and the registered beat presented on the R channel.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rcnt_q    <= rcnt_d;
            rburst_q  <= rburst_d;
            rbad_q    <= rbad_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && r_final) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read datapath: fetch beat 0 on AR handshake, the next beat on each R handshake,
    // so the presented beat stays frozen while the master stalls.
    always_comb begin
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rcnt_d     = rcnt_q;
        rburst_d   = rburst_q;
        rbad_d     = rbad_q;
        rlast_d    = rlast_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        fetch_en   = 1'b0;
        fetch_addr = raddr_q;
        fetch_bad  = rbad_q;
        if (ar_hs) begin
            raddr_d    = araddr;
            rlen_d     = arlen;
            rcnt_d     = '0;
            rburst_d   = arburst;
            rbad_d     = burst_bad(arsize, arburst);
            rid_d      = arid;
            rlast_d    = (arlen == 4'd0);
            fetch_en   = 1'b1;
            fetch_addr = araddr;
            fetch_bad  = burst_bad(arsize, arburst);
        end else if (r_hs) begin
            if (r_final) begin
                rlast_d = 1'b0;
            end else begin
                fetch_en   = 1'b1;
                fetch_addr = next_addr(raddr_q, rburst_q);
                raddr_d    = fetch_addr;
                rcnt_d     = rcnt_q + 4'd1;
                rlast_d    = ((rcnt_q + 4'd1) == rlen_q);
            end
        end
        fetch_err = fetch_bad | ~in_range(fetch_addr);
        if (fetch_en) begin
            rdata_d = fetch_err ? '0 : mem[word_idx(fetch_addr)];
            rresp_d = fetch_err ? 2'b10 : 2'b00;
        end
    end

    // Read channel outputs decoded from state and the beat registers.
    always_comb begin
        arready = (r_state_q == R_IDLE) & ~areset;
        rvalid  = (r_state_q == R_DATA);
        rid     = rid_q;
        rdata   = rdata_q;
        rresp   = rresp_q;
        rlast   = rlast_q;
    end

endmodule

// File: tb/tb_peripheral_bfm_slave_axi4.sv
// Bench for peripheral_bfm_slave_axi4: a table of write/read bursts checked
// against a reference memory and per-entry expected responses, plus a
// hand-written mid-burst reset sequence.
module tb_peripheral_bfm_slave_axi4;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [3:0]  awid = '0, wid = '0, arid = '0, bid, rid;
    logic [31:0] awadr = '0, araddr = '0, wrdata = '0, rdata;
    logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
    logic        awvalid = 1'b0, awready, wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bvalid, bready = 1'b0, arvalid = 1'b0, arready;
    logic        rlast, rvalid, rready = 1'b0;

    peripheral_bfm_slave_axi4 #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .aclk(aclk), .areset(areset),
        .awid(awid), .awadr(awadr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] base;
        logic [3:0]  strb;
        bit          early;
        bit          rnd;
        logic [1:0]  exp_resp;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_rresp = '0;
    bit          rand_rready = 1'b0;

    function automatic bit m_ok(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 2) < 32'(DEPTH));
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic vec_t mk(bit wr, logic [3:0] id, logic [31:0] addr, logic [3:0] len,
                                logic [2:0] size, logic [1:0] burst, logic [31:0] base,
                                logic [3:0] strb, bit early, bit rnd, logic [1:0] er,
                                logic [31:0] el);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
        v.base = base; v.strb = strb; v.early = early; v.rnd = rnd; v.exp_resp = er;
        v.exp_last = el;
        return v;
    endfunction

    // rready: held high, or randomised each cycle when requested
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            rready = rand_rready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // R channel monitor: pops the scoreboard on each handshake, checks stall stability
    initial begin
        bit          stalled;
        logic [31:0] sd;
        logic        sl;
        beat_t       e;
        stalled = 1'b0;
        sd = '0;
        sl = 1'b0;
        forever begin
            @(negedge aclk);
            if (rvalid) begin
                if (stalled) begin
                    check("r_stall_data", rdata, sd);
                    check("r_stall_last", 32'(rlast), 32'(sl));
                end
                if (rready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected_beat actual rdata=0x%0h expected no beat", rdata);
                    end else begin
                        e = sb.pop_front();
                        check("r_data", rdata, e.data);
                        check("r_resp", 32'(rresp), 32'(e.resp));
                        check("r_last", 32'(rlast), 32'(e.last));
                        check("r_id", 32'(rid), 32'(e.id));
                        last_rdata = rdata;
                        last_rresp = rresp;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = rdata;
                    sl = rlast;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic do_write(input vec_t v);
        int          n;
        int          waits;
        logic [31:0] a;
        bit          bad;
        logic [31:0] d;
        awvalid = 1'b1; awid = v.id; awadr = v.addr; awlen = v.len;
        awsize = v.size; awburst = v.burst;
        n = 0;
        while (!awready && n < 50) begin @(posedge aclk); #1; n++; end
        check("aw_ready", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
        a = v.addr;
        bad = (v.size != 3'b010) || v.burst[1];
        waits = 0;
        for (int b = 0; b <= int'(v.len); b++) begin
            wvalid = 1'b1;
            wid = v.id;
            d = v.base + 32'(b);
            wrdata = d;
            wstrb = v.strb;
            wlast = v.early ? (b == 0) : (b == int'(v.len));
            n = 0;
            while (!wready && n < 50) begin @(posedge aclk); #1; n++; waits++; end
            @(posedge aclk); #1;
            if (!bad && m_ok(a)) begin
                for (int l = 0; l < 4; l++)
                    if (v.strb[l]) model[m_idx(a)][8*l +: 8] = d[8*l +: 8];
            end
            if (v.burst == 2'b01) a = a + 32'd4;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        check("w_no_stall", 32'(waits), 32'd0);
        check("w_ready_done", 32'(wready), 32'd0);
        check("b_valid_next", 32'(bvalid), 32'd1);
        check("b_id", 32'(bid), 32'(v.id));
        check("b_resp", 32'(bresp), 32'(v.exp_resp));
        @(posedge aclk); #1;
        check("b_valid_hold", 32'(bvalid), 32'd1);
        check("b_resp_hold", 32'(bresp), 32'(v.exp_resp));
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        check("b_valid_drop", 32'(bvalid), 32'd0);
        check("aw_ready_after_b", 32'(awready), 32'd1);
    endtask

    task automatic do_read(input vec_t v);
        int          n;
        logic [31:0] a;
        bit          bad;
        bit          err;
        beat_t       e;
        a = v.addr;
        bad = (v.size != 3'b010) || v.burst[1];
        for (int b = 0; b <= int'(v.len); b++) begin
            err = bad || !m_ok(a);
            e.data = err ? 32'h0 : model[m_idx(a)];
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == int'(v.len));
            e.id = v.id;
            sb.push_back(e);
            if (v.burst == 2'b01) a = a + 32'd4;
        end
        rand_rready = v.rnd;
        arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len;
        arsize = v.size; arburst = v.burst;
        n = 0;
        while (!arready && n < 50) begin @(posedge aclk); #1; n++; end
        check("ar_ready", 32'(arready), 32'd1);
        @(posedge aclk); #1;
        arvalid = 1'b0;
        check("r_valid_first", 32'(rvalid), 32'd1);
        n = 0;
        while (sb.size() != 0 && n < 500) begin @(posedge aclk); n++; end
        #1;
        check("r_done_in_budget", 32'(sb.size()), 32'd0);
        sb.delete();
        rand_rready = 1'b0;
        check("r_valid_end", 32'(rvalid), 32'd0);
        check("ar_ready_end", 32'(arready), 32'd1);
        check("r_final_data", last_rdata, v.exp_last);
        check("r_final_resp", 32'(last_rresp), 32'(v.exp_resp));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"}, 32'(wready), 32'd0);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rlast"}, 32'(rlast), 32'd0);
        check({tag, "_bid"}, 32'(bid), 32'd0);
        check({tag, "_bresp"}, 32'(bresp), 32'd0);
        check({tag, "_rid"}, 32'(rid), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_rresp"}, 32'(rresp), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        //          wr id    addr          len   size  burst  base          strb  er rn resp   last
        tbl.push_back(mk(1, 4'd3, 32'h10,  4'd3, 3'd2, 2'b01, 32'hA0,       4'hF, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 4'd5, 32'h10,  4'd3, 3'd2, 2'b01, 0,            0,    0, 0, 2'b00, 32'hA3));
        tbl.push_back(mk(1, 4'd1, 32'h0,   4'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 0));
        tbl.push_back(mk(1, 4'd2, 32'h0,   4'd0, 3'd2, 2'b01, 32'h11223344, 4'h5, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 4'd2, 32'h0,   4'd0, 3'd2, 2'b01, 0,            0,    0, 0, 2'b00, 32'hFF22FF44));
        tbl.push_back(mk(1, 4'd4, 32'h20,  4'd2, 3'd2, 2'b00, 32'h1,        4'hF, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 4'd4, 32'h20,  4'd0, 3'd2, 2'b01, 0,            0,    0, 0, 2'b00, 32'h3));
        tbl.push_back(mk(0, 4'd7, 32'h20,  4'd1, 3'd2, 2'b00, 0,            0,    0, 0, 2'b00, 32'h3));
        tbl.push_back(mk(1, 4'd8, 32'h3FC, 4'd1, 3'd2, 2'b01, 32'h55,       4'hF, 0, 0, 2'b10, 0));
        tbl.push_back(mk(0, 4'd8, 32'h3FC, 4'd1, 3'd2, 2'b01, 0,            0,    0, 0, 2'b10, 32'h0));
        tbl.push_back(mk(1, 4'd9, 32'h10,  4'd0, 3'd1, 2'b01, 32'hDEAD,     4'hF, 0, 0, 2'b10, 0));
        tbl.push_back(mk(0, 4'd9, 32'h10,  4'd0, 3'd2, 2'b01, 0,            0,    0, 0, 2'b00, 32'hA0));
        tbl.push_back(mk(1, 4'hA, 32'h30,  4'd1, 3'd2, 2'b01, 32'h77,       4'hF, 1, 0, 2'b10, 0));
        tbl.push_back(mk(0, 4'hA, 32'h30,  4'd1, 3'd2, 2'b01, 0,            0,    0, 0, 2'b00, 32'h78));
        tbl.push_back(mk(1, 4'hB, 32'h50,  4'd1, 3'd2, 2'b10, 32'h99,       4'hF, 0, 0, 2'b10, 0));
        tbl.push_back(mk(0, 4'hB, 32'h50,  4'd0, 3'd2, 2'b10, 0,            0,    0, 0, 2'b10, 32'h0));
        tbl.push_back(mk(0, 4'hC, 32'hFFFFFFFC, 4'd1, 3'd2, 2'b01, 0,       0,    0, 0, 2'b00, 32'hFF22FF44));
        tbl.push_back(mk(1, 4'hD, 32'h100, 4'd15, 3'd2, 2'b01, 32'h1000,    4'hF, 0, 0, 2'b00, 0));
        tbl.push_back(mk(0, 4'hE, 32'h100, 4'd15, 3'd2, 2'b01, 0,           0,    0, 1, 2'b00, 32'h100F));

        // reset state
        repeat (2) @(posedge aclk);
        #1;
        check_all_zero("reset");
        areset = 1'b0;
        #1;
        check("aw_ready_release", 32'(awready), 32'd1);
        check("ar_ready_release", 32'(arready), 32'd1);
        @(posedge aclk); #1;

        foreach (tbl[i]) begin
            if (tbl[i].wr) do_write(tbl[i]);
            else do_read(tbl[i]);
        end

        // areset in the middle of a 4-beat write, after beat 1
        awvalid = 1'b1; awid = 4'd6; awadr = 32'h40; awlen = 4'd3;
        awsize = 3'd2; awburst = 2'b01;
        @(posedge aclk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1; wrdata = 32'hB0 + 32'(b); wstrb = 4'hF; wlast = 1'b0;
            check("mid_wready", 32'(wready), 32'd1);
            @(posedge aclk); #1;
            model[m_idx(32'h40) + b] = 32'hB0 + 32'(b);
        end
        wvalid = 1'b0;
        areset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        #1;
        check("aw_ready_after_reset", 32'(awready), 32'd1);
        @(posedge aclk); #1;
        v = mk(1, 4'd6, 32'h80, 4'd3, 3'd2, 2'b01, 32'hC0, 4'hF, 0, 0, 2'b00, 0);
        do_write(v);
        v = mk(0, 4'd6, 32'h40, 4'd1, 3'd2, 2'b01, 0, 0, 0, 0, 2'b00, 32'hB1);
        do_read(v);
        v = mk(0, 4'd6, 32'h80, 4'd3, 3'd2, 2'b01, 0, 0, 0, 1, 2'b00, 32'hC3);
        do_read(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
